// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : fifo_uart_tx
// Desc     : Drains a synchronous FIFO one word per frame and serialises it
//            LSB-first as start + WIDTH data + [even parity] + stop.
//            Parity bit is present only when UART_TX_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_uart_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_r_en,
  output logic             tx,
  output logic             busy,
  output logic             tx_done
);

  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = $clog2(WIDTH + 1);
  localparam logic [DIV_W-1:0] c_div_last = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] c_bit_last = BIT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
`ifdef UART_TX_PARITY_EN
    PAR   = 3'd5,
`endif
    STOP  = 3'd6
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [DIV_W-1:0]   r_div;
  logic [BIT_W-1:0]   r_bit;
  logic [WIDTH-1:0]   r_shift;
  logic [WIDTH-1:0]   w_shift_next;
  logic               r_tx;
  logic               w_tx_next;
  logic               w_bit_end;
  logic               w_last_bit;
`ifdef UART_TX_PARITY_EN
  logic               r_parity;
`endif

  assign w_bit_end    = (r_div == c_div_last);
  assign w_last_bit   = (r_bit == c_bit_last);
  assign w_shift_next = r_shift >> 1;
  assign busy         = (r_state != IDLE);
  assign tx           = r_tx;

  always_comb begin
    w_next_state = r_state;
    fifo_r_en    = 1'b0;
    tx_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (!fifo_empty) w_next_state = FETCH;
      end
      FETCH: begin
        fifo_r_en    = 1'b1;
        w_next_state = LOAD;
      end
      LOAD: begin
        w_next_state = START;
      end
      START: begin
        if (w_bit_end) w_next_state = DATA;
      end
      DATA: begin
        if (w_bit_end && w_last_bit) begin
`ifdef UART_TX_PARITY_EN
          w_next_state = PAR;
`else
          w_next_state = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PAR: begin
        if (w_bit_end) w_next_state = STOP;
      end
`endif
      STOP: begin
        if (w_bit_end) begin
          tx_done      = 1'b1;
          w_next_state = fifo_empty ? IDLE : FETCH;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Line level is precomputed from the next state so tx comes straight off a flop.
  always_comb begin
    w_tx_next = 1'b1;
    case (w_next_state)
      START: w_tx_next = 1'b0;
      DATA:  w_tx_next = (r_state == DATA && w_bit_end) ? w_shift_next[0] : r_shift[0];
`ifdef UART_TX_PARITY_EN
      PAR:   w_tx_next = r_parity;
`endif
      default: w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_tx    <= 1'b1;
      r_div   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
`ifdef UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_state <= w_next_state;
      r_tx    <= w_tx_next;

      if (r_state != IDLE && r_state != FETCH && r_state != LOAD) begin
        r_div <= w_bit_end ? '0 : r_div + 1'b1;
      end else begin
        r_div <= '0;
      end

      if (r_state == DATA) begin
        if (w_bit_end) r_bit <= r_bit + 1'b1;
      end else begin
        r_bit <= '0;
      end

      if (r_state == LOAD) begin
        r_shift <= fifo_data;
      end else if (r_state == DATA && w_bit_end) begin
        r_shift <= w_shift_next;
      end

`ifdef UART_TX_PARITY_EN
      // The shifter is consumed during DATA, so parity is taken from the loaded word.
      if (r_state == LOAD) r_parity <= ^fifo_data;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_uart_tx
// Desc     : Self-checking bench for fifo_uart_tx with a FIFO model and a
//            per-cycle expected line waveform built from the frame format.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;

  localparam int WIDTH = 8;
  localparam int CPB   = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = WIDTH + 3;
`else
  localparam int NBITS = WIDTH + 2;
`endif
  localparam int FRAME = NBITS * CPB;

  logic             clk;
  logic             rst;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_r_en;
  logic             tx;
  logic             busy;
  logic             tx_done;

  fifo_uart_tx #(.WIDTH(WIDTH), .CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_r_en  (fifo_r_en),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic tx; logic done; } exp_t;
  typedef struct { logic [7:0] word; logic [9:0] frame; logic par; } vec_t;

  exp_t       exp_q[$];
  logic [7:0] fifo_q[$];
  vec_t       vecs[6];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Expected line: one idle-high LOAD cycle, then every frame bit held CPB cycles.
  task automatic append_frame(input logic [7:0] w);
    logic v;
    exp_q.push_back('{tx: 1'b1, done: 1'b0});
    for (int b = 0; b < NBITS; b++) begin
      if (b == 0)               v = 1'b0;
      else if (b <= WIDTH)      v = w[b-1];
      else if (b == NBITS - 1)  v = 1'b1;
      else                      v = ^w;
      for (int k = 0; k < CPB; k++)
        exp_q.push_back('{tx: v, done: (b == NBITS - 1 && k == CPB - 1)});
    end
  endtask

  task automatic push(input logic [7:0] w);
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic tick();
    logic       rst_s, empty_s;
    logic [3:0] act, expv;
    logic [7:0] w;
    exp_t       e;
    rst_s   = rst;
    empty_s = fifo_empty;
    @(negedge clk);
    cyc++;
    if (rst_s) begin
      exp_q.delete();
      expv = 4'b0001;
    end else if (exp_q.size() > 0) begin
      e    = exp_q.pop_front();
      expv = {1'b0, 1'b1, e.done, e.tx};
    end else begin
      expv = {~empty_s, ~empty_s, 1'b0, 1'b1};
    end
    act = {fifo_r_en, busy, tx_done, tx};
    check("line {ren,busy,done,tx}", {28'd0, act}, {28'd0, expv});
    if (fifo_r_en === 1'b1) begin
      if (fifo_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL read_while_empty: got fifo_r_en=1 expected 0 (cycle %0d)", cyc);
      end else begin
        w          = fifo_q.pop_front();
        fifo_data  = w;
        fifo_empty = (fifo_q.size() == 0);
        if (expv[3]) append_frame(w);
      end
    end
  endtask

  task automatic wait_ren(input string name);
    int j;
    for (j = 0; j < 12; j++) begin
      tick();
      if (fifo_r_en === 1'b1) break;
    end
    check(name, (j < 12), 1);
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 400; i++) begin
      if (exp_q.size() == 0 && fifo_q.size() == 0 && busy === 1'b0) break;
      tick();
    end
    check("wait_idle_timeout", (i < 400), 1);
  endtask

  // Called right after the fetch cycle; samples each bit mid-period.
  task automatic capture_frame(output logic [10:0] got, output logic done_ok);
    got     = '0;
    done_ok = 1'b1;
    tick();
    for (int b = 0; b < NBITS; b++) begin
      for (int k = 0; k < CPB; k++) begin
        tick();
        if (k == CPB / 2) got[b] = tx;
        if (tx_done !== (b == NBITS - 1 && k == CPB - 1)) done_ok = 1'b0;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] got, expf;
    logic        dok;
    int          c1, c2, cnt_ren, cnt_tx, cnt_busy;

    vecs[0] = '{word: 8'hA5, frame: 10'b1_10100101_0, par: 1'b0};
    vecs[1] = '{word: 8'h00, frame: 10'b1_00000000_0, par: 1'b0};
    vecs[2] = '{word: 8'hFF, frame: 10'b1_11111111_0, par: 1'b0};
    vecs[3] = '{word: 8'h3C, frame: 10'b1_00111100_0, par: 1'b0};
    vecs[4] = '{word: 8'h07, frame: 10'b1_00000111_0, par: 1'b1};
    vecs[5] = '{word: 8'h80, frame: 10'b1_10000000_0, par: 1'b1};

    rst        = 1'b1;
    fifo_empty = 1'b1;
    fifo_data  = '0;
    tick();
    tick();
    check("reset_tx", {31'd0, tx}, 1);
    check("reset_busy", {31'd0, busy}, 0);

    // Reset held with a non-empty FIFO; fetch comes one cycle after release.
    push(8'h5A);
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b0;
    tick();
    check("ren_after_rst_release", {31'd0, fifo_r_en}, 1);
    wait_idle();

    for (int i = 0; i < 6; i++) begin
      push(vecs[i].word);
      wait_ren("vec_ren_seen");
      capture_frame(got, dok);
`ifdef UART_TX_PARITY_EN
      expf = {vecs[i].frame[9], vecs[i].par, vecs[i].frame[8:0]};
`else
      expf = {1'b0, vecs[i].frame};
`endif
      check($sformatf("vec%0d_frame", i), {21'd0, got}, {21'd0, expf});
      check($sformatf("vec%0d_done_pos", i), {31'd0, dok}, 1);
      tick();
      check($sformatf("vec%0d_busy_drop", i), {31'd0, busy}, 0);
    end

    // Back-to-back frames.
    push(8'h00);
    push(8'hFF);
    wait_ren("b2b_ren1");
    c1 = cyc;
    capture_frame(got, dok);
    check("b2b_frame1_data", {24'd0, got[8:1]}, 32'h00);
    wait_ren("b2b_ren2");
    c2 = cyc;
    check("b2b_ren_spacing", c2 - c1, FRAME + 2);
    capture_frame(got, dok);
    check("b2b_frame2_data", {24'd0, got[8:1]}, 32'hFF);
    check("b2b_frame2_done", {31'd0, dok}, 1);
    wait_idle();

    // Empty FIFO for a long stretch.
    cnt_ren = 0; cnt_tx = 0; cnt_busy = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (fifo_r_en !== 1'b0) cnt_ren++;
      if (tx !== 1'b1)        cnt_tx++;
      if (busy !== 1'b0)      cnt_busy++;
    end
    check("empty_ren_count", cnt_ren, 0);
    check("empty_tx_low_count", cnt_tx, 0);
    check("empty_busy_count", cnt_busy, 0);

    // Reset during data bit 3 of 0x3C.
    push(8'h3C);
    wait_ren("mid_rst_ren");
    for (int i = 0; i < 1 + CPB + 3 * CPB + 1; i++) tick();
    rst = 1'b1;
    tick();
    check("mid_rst_tx", {31'd0, tx}, 1);
    check("mid_rst_busy", {31'd0, busy}, 0);
    tick();
    tick();
    rst = 1'b0;
    cnt_ren = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (fifo_r_en !== 1'b0) cnt_ren++;
    end
    check("mid_rst_no_reread", cnt_ren, 0);
    push(8'h11);
    wait_ren("post_rst_ren");
    wait_idle();

    // Random traffic with occasional resets.
    for (int n = 0; n < 2000; n++) begin
      if (($urandom % 6) == 0 && fifo_q.size() < 4) push(8'($urandom));
      rst = (($urandom % 300) == 0);
      tick();
    end
    rst = 1'b0;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
